// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point types and helpers for the pipelined FPU
// datapaths (fp_add_pipe, and later fp_mul_pipe).
//   fp_flags_t  - per-result exception flags {invalid, overflow, underflow, inexact}
//   fp_class_t  - operand classification
//   bias()      - exponent bias for a given exponent width
//   canon_qnan()- canonical quiet NaN bit pattern, right-aligned in 64 bits
package fp_pkg;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_t;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // sign 0, exponent all ones, fraction MSB set, remaining fraction bits clear
  function automatic logic [63:0] canon_qnan(input int unsigned exp_w,
                                             input int unsigned man_w);
    logic [63:0] e_ones;
    e_ones = (64'd1 << exp_w) - 64'd1;
    return (e_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   din   - input vector, MSB first
//   count - number of zeros above the most significant set bit;
//           an all-zero input returns WIDTH
module fp_lzc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]             din,
  output logic [$clog2(WIDTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  // scan upward so the highest set bit is the last one to write count
  always_comb begin
    count = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (din[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: pipelined floating-point adder/subtractor, RNE rounding,
// flush-to-zero for denormals, valid/ready handshake with full-pipeline stall.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake (a, b, op: 0 = a+b, 1 = a-b)
//   out_valid/out_ready - result handshake (result, flags)
//   flags               - {invalid, overflow, underflow, inexact}, per result
// Register chain: operand capture -> S1 (align) -> S2 (add + lzc) -> S3 output
// (normalise/round/pack), so a transfer on edge N shows out_valid after N+3.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic                     op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [3:0]               flags
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned MW  = EXP_W + MAN_W;   // magnitude (exp|frac)
  localparam int unsigned M4  = MAN_W + 4;       // hidden|frac|G|R|S
  localparam int unsigned M5  = MAN_W + 5;       // carry + M4
  localparam int unsigned LZW = $clog2(M5 + 1);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [W-1:0]     QNAN    = W'(canon_qnan(EXP_W, MAN_W));

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  function automatic fp_class_t cls(input logic [EXP_W-1:0] e,
                                    input logic [MAN_W-1:0] f);
    if (e == '0)           return FP_ZERO;
    else if (e != EXP_MAX) return FP_NORM;
    else if (f == '0)      return FP_INF;
    else if (f[MAN_W-1])   return FP_QNAN;
    else                   return FP_SNAN;
  endfunction

  // ---------------- operand capture ----------------
  logic         r0_valid;
  logic [W-1:0] r0_a, r0_b;
  logic         r0_op;

  // ---------------- S1: classify, swap, align ----------------
  fp_class_t         ca, cb;
  logic              sa, sb;
  logic [MW-1:0]     mag_a, mag_b, mag_l, mag_s;
  logic              swap, sl, ss;
  logic [EXP_W-1:0]  el, es, d;
  logic [MAN_W:0]    ml, ms;
  logic [2*M4-1:0]   sh;
  logic [M4-1:0]     ms_al;
  logic              c1_spec, c1_inv;
  logic [W-1:0]      c1_spec_res;

  always_comb begin
    sa = r0_a[W-1];
    sb = r0_b[W-1] ^ r0_op;
    ca = cls(r0_a[W-2 -: EXP_W], r0_a[MAN_W-1:0]);
    cb = cls(r0_b[W-2 -: EXP_W], r0_b[MAN_W-1:0]);

    c1_spec     = 1'b0;
    c1_inv      = 1'b0;
    c1_spec_res = '0;
    if (ca == FP_QNAN || ca == FP_SNAN || cb == FP_QNAN || cb == FP_SNAN) begin
      c1_spec     = 1'b1;
      c1_spec_res = QNAN;
      c1_inv      = (ca == FP_SNAN) || (cb == FP_SNAN);
    end else if (ca == FP_INF && cb == FP_INF && sa != sb) begin
      c1_spec     = 1'b1;
      c1_spec_res = QNAN;
      c1_inv      = 1'b1;
    end else if (ca == FP_INF) begin
      c1_spec     = 1'b1;
      c1_spec_res = {sa, EXP_MAX, {MAN_W{1'b0}}};
    end else if (cb == FP_INF) begin
      c1_spec     = 1'b1;
      c1_spec_res = {sb, EXP_MAX, {MAN_W{1'b0}}};
    end

    // zero/denormal operands become an all-zero magnitude (FTZ)
    mag_a = (ca == FP_ZERO) ? '0 : r0_a[MW-1:0];
    mag_b = (cb == FP_ZERO) ? '0 : r0_b[MW-1:0];
    swap  = mag_b > mag_a;
    mag_l = swap ? mag_b : mag_a;
    mag_s = swap ? mag_a : mag_b;
    sl    = swap ? sb : sa;
    ss    = swap ? sa : sb;
    el    = mag_l[MW-1:MAN_W];
    es    = mag_s[MW-1:MAN_W];
    ml    = {|el, mag_l[MAN_W-1:0]};
    ms    = {|es, mag_s[MAN_W-1:0]};
    d     = el - es;

    // shift into a double-width window; everything below the window folds into S
    sh = '0;
    if (32'(d) > 32'(MAN_W + 3)) begin
      ms_al = {{(M4-1){1'b0}}, |ms};
    end else begin
      sh    = {ms, 3'b000, {M4{1'b0}}} >> d;
      ms_al = {sh[2*M4-1:M4+1], sh[M4] | (|sh[M4-1:0])};
    end
  end

  logic             s1_valid, s1_spec, s1_inv, s1_sign, s1_sub, s1_zsign;
  logic [W-1:0]     s1_spec_res;
  logic [EXP_W-1:0] s1_exp;
  logic [M4-1:0]    s1_ml, s1_ms;

  // ---------------- S2: effective add/sub, leading-zero count ----------------
  logic [M5-1:0]  c2_sum;
  logic [LZW-1:0] c2_lz;

  always_comb begin
    if (s1_sub) c2_sum = {1'b0, s1_ml} - {1'b0, s1_ms};
    else        c2_sum = {1'b0, s1_ml} + {1'b0, s1_ms};
  end

  fp_lzc #(.WIDTH(M5)) u_lzc (
    .din   (c2_sum),
    .count (c2_lz)
  );

  logic             s2_valid, s2_spec, s2_inv, s2_sign, s2_zsign;
  logic [W-1:0]     s2_spec_res;
  logic [EXP_W-1:0] s2_exp;
  logic [M5-1:0]    s2_sum;
  logic [LZW-1:0]   s2_lz;

  // ---------------- S3: normalise, round, pack ----------------
  logic [M5-2:0]  nrm;
  logic [MAN_W:0] mant;
  logic           g, r, s, rnd;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] frac;
  int             e_n, e_r;
  logic [W-1:0]   c3_res;
  fp_flags_t      c3_flags;

  always_comb begin
    // a carry shifts right by one; otherwise shift left so the hidden bit lands on top
    if (s2_sum[M5-1]) nrm = {s2_sum[M5-1:2], s2_sum[1] | s2_sum[0]};
    else if (s2_lz != '0) nrm = s2_sum[M5-2:0] << (s2_lz - LZW'(1));
    else nrm = s2_sum[M5-2:0];
    e_n  = int'(s2_exp) + 1 - int'(s2_lz);
    mant = nrm[M5-2:3];
    g    = nrm[2];
    r    = nrm[1];
    s    = nrm[0];
    rnd  = g & (r | s | mant[0]);
    mr   = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd};
    e_r  = e_n + int'(mr[MAN_W+1]);
    frac = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];

    c3_flags = '0;
    if (s2_spec) begin
      c3_res           = s2_spec_res;
      c3_flags.invalid = s2_inv;
    end else if (s2_sum == '0) begin
      c3_res = {s2_zsign, {(W-1){1'b0}}};
    end else if (e_n <= 0) begin
      c3_res             = {s2_sign, {(W-1){1'b0}}};
      c3_flags.underflow = 1'b1;
      c3_flags.inexact   = 1'b1;
    end else if (e_r >= int'(EXP_MAX)) begin
      c3_res            = {s2_sign, EXP_MAX, {MAN_W{1'b0}}};
      c3_flags.overflow = 1'b1;
      c3_flags.inexact  = 1'b1;
    end else begin
      c3_res           = {s2_sign, e_r[EXP_W-1:0], frac};
      c3_flags.inexact = g | r | s;
    end
  end

  fp_flags_t out_flags;
  assign flags = out_flags;

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_flags <= '0;
    end else if (adv) begin
      r0_valid  <= in_valid;
      s1_valid  <= r0_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        result    <= c3_res;
        out_flags <= c3_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      r0_a        <= a;
      r0_b        <= b;
      r0_op       <= op;
      s1_spec     <= c1_spec;
      s1_inv      <= c1_inv;
      s1_spec_res <= c1_spec_res;
      s1_sign     <= sl;
      s1_sub      <= sl ^ ss;
      s1_zsign    <= sa & sb;
      s1_exp      <= el;
      s1_ml       <= {ml, 3'b000};
      s1_ms       <= ms_al;
      s2_spec     <= s1_spec;
      s2_inv      <= s1_inv;
      s2_spec_res <= s1_spec_res;
      s2_sign     <= s1_sign;
      s2_zsign    <= s1_zsign;
      s2_exp      <= s1_exp;
      s2_sum      <= c2_sum;
      s2_lz       <= c2_lz;
    end
  end

endmodule
